serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised bit-serial ripple-carry adder. It is the sequential successor of the single-bit full adder.
- Takes WIDTH-bit operands a, b and carry-in cin on a start handshake.
- Processes one bit per clock, LSB first, through one full-adder cell with a registered carry.
- Presents a registered {cout,sum} result with a one-cycle done pulse.
- Sits as a small arithmetic unit behind a controller that issues start and waits for done.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; accepted only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- cin  input  1  carry-in; sampled on the accepting edge.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered sum; held until the next completion.
- cout  output  1  registered carry-out; held until the next completion.

Behaviour:
- Reset: synchronous, active-high. On a reset edge: state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers, carry and counter cleared.
- Reset mid-operation: the in-flight operation is discarded with no done pulse, and outputs clear to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1 at edge k:
  - a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, state<=RUN.
  - Otherwise stay in IDLE.
- RUN: at each edge:
  - s = a_sh[0]^b_sh[0]^carry.
  - carry <= majority(a_sh[0], b_sh[0], carry).
  - s is shifted into the MSB of s_sh; a_sh and b_sh shift right by 1; cnt++.
  - On the edge where cnt==WIDTH-1: sum <= final s_sh value (including the current s), cout <= new carry, state <= DONE.
- DONE: done=1 for exactly this cycle; next edge -> IDLE.
- Latency:
  - start accepted at edge k; sum/cout updated at edge k+WIDTH.
  - done high during the cycle following edge k+WIDTH.
  - Back-to-back issue interval: WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored and not queued. a/b/cin changes after acceptance have no effect.
- sum/cout change only at completion edges (or reset); partial results are never visible on outputs.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1). There is no overflow flag; the carry wraps into cout.
- WIDTH=1: RUN lasts one cycle; done follows 1 cycle after acceptance.
- start held high continuously: a new operation is accepted on every IDLE cycle, so one operation per WIDTH+2 cycles.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - When sub=1: b_sh is loaded with ~b, carry is initialised to 1 and cin is ignored, so sum = a - b mod 2^WIDTH.
  - cout=1 means no borrow (a>=b unsigned).
  - When sub=0: behaviour is identical to the base adder.
- Undefined: port sub is absent; add-only behaviour as specified above.

Test Plan (WIDTH=8 unless stated):
- rst held 2 cycles, then released -> busy=0, done=0, sum=0x00, cout=0. Assert rst during RUN at cycle 3 -> next edge IDLE, all outputs 0, no done pulse.
- Exhaustive sweep with WIDTH=1 over all 8 {a,b,cin} combinations -> {cout,sum} equals a+b+cin for each, done 1 cycle after each acceptance.
- a=0xFF, b=0x01, cin=0 -> done exactly 8 cycles after the accepting edge, sum=0x00, cout=1. Then a=0x7F, b=0x80, cin=1 -> sum=0x00, cout=1.
- Accept a=0x12, b=0x34, cin=0; pulse start with a=0xAA while busy and change a/b mid-RUN -> result sum=0x46, cout=0; the second start is ignored and only one done pulse occurs.
- start held high with 3 random operand sets, checked against a golden a+b+cin -> accept edges 10 cycles apart, each done a single-cycle pulse, and sum stable between done pulses.
- With SERIAL_ADDER_SUB_EN defined: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0. Then a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, {cout,sum}=a+b+cin; SERIAL_ADDER_SUB_EN adds sub port (a-b).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_nx;
  logic [CNT_W-1:0] cnt;
  logic carry, s, c_nx, last;
  always_comb begin
    s = a_sh[0] ^ b_sh[0] ^ carry;
    c_nx = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    s_nx = WIDTH'({s, s_sh} >> 1);
    last = cnt == CNT_W'(WIDTH - 1);
    state_nx = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        a_sh <= a;
        cnt <= '0;
`ifdef SERIAL_ADDER_SUB_EN
        b_sh <= sub ? ~b : b;
        carry <= sub | cin;
`else
        b_sh <= b;
        carry <= cin;
`endif
      end else if (state == RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        s_sh <= s_nx;
        carry <= c_nx;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          sum <= s_nx;
          cout <= c_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vector table, WIDTH=1 sweep, random ops and multi-cycle corner sequences.
module tb_serial_adder;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, cin = 1'b0, busy, done, cout;
  logic [7:0] a = '0, b = '0, sum;
  logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, busy1, done1, sum1, cout1;
`ifdef SERIAL_ADDER_SUB_EN
  logic sub = 1'b0, sub1 = 1'b0;
`endif
  int total = 0, bad = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                     output logic [7:0] so, output logic co);
    int lat;
    lat = -1;
    @(negedge clk);
    start = 1'b1; a = ai; b = bi; cin = ci;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    chk("latency8", 64'(lat), 64'd8);
    so = sum;
    co = cout;
    @(negedge clk);
    chk("done_width8", 64'(done), 64'd0);
  endtask

  task automatic op1(input logic ai, input logic bi, input logic ci,
                     output logic so, output logic co);
    int lat;
    lat = -1;
    @(negedge clk);
    start1 = 1'b1; a1 = ai; b1 = bi; cin1 = ci;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done1) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    chk("latency1", 64'(lat), 64'd1);
    so = sum1;
    co = cout1;
    @(negedge clk);
    chk("done_width1", 64'(done1), 64'd0);
  endtask

  initial begin
    vec_t vecs[6];
    logic [7:0] s, ra, rb;
    logic c, s1, c1, rc;
    logic [8:0] m;
    logic [8:0] res[3];
    logic [7:0] oa[3], ob[3];
    logic oc[3];
    int n;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);

    for (int i = 0; i < 8; i++) begin
      op1(i[0], i[1], i[2], s1, c1);
      m = 9'(i[0]) + 9'(i[1]) + 9'(i[2]);
      chk("w1_sum", 64'(s1), 64'(m[0]));
      chk("w1_cout", 64'(c1), 64'(m[1]));
    end

    foreach (vecs[i]) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, s, c);
      chk("vec_sum", 64'(s), 64'(vecs[i].sum));
      chk("vec_cout", 64'(c), 64'(vecs[i].cout));
    end

    // reset during RUN: outputs clear and the operation never completes
    @(negedge clk);
    start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_cout", 64'(cout), 64'd0);
    rst = 1'b0;
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("midrst_no_done", 64'(n), 64'd0);

    // start while busy is ignored; operand changes after acceptance have no effect
    @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    s = '0;
    c = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (i == 1) begin start = 1'b1; a = 8'hAA; end
      if (i == 2) start = 1'b0;
      if (i == 4) begin a = 8'h55; b = 8'h66; cin = 1'b1; end
      if (done) begin n++; s = sum; c = cout; end
    end
    chk("busy_done_count", 64'(n), 64'd1);
    chk("busy_sum", 64'(s), 64'h46);
    chk("busy_cout", 64'(c), 64'd0);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      op8(ra, rb, rc, s, c);
      m = 9'(ra) + 9'(rb) + 9'(rc);
      chk("rand_sum", 64'(s), 64'(m[7:0]));
      chk("rand_cout", 64'(c), 64'(m[8]));
    end

    // start held high: accepts every WIDTH+2 cycles
    for (int j = 0; j < 3; j++) begin
      oa[j] = 8'($urandom); ob[j] = 8'($urandom); oc[j] = 1'($urandom);
      res[j] = 9'(oa[j]) + 9'(ob[j]) + 9'(oc[j]);
    end
    @(negedge clk);
    start = 1'b1; a = oa[0]; b = ob[0]; cin = oc[0];
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      chk("held_done", 64'(done), 64'(t % 10 == 8));
      chk("held_busy", 64'(busy), 64'(t % 10 != 9));
      if (t >= 8) chk("held_result", 64'({cout, sum}), 64'(res[(t - 8) / 10]));
      if (t / 10 + 1 < 3) begin a = oa[t / 10 + 1]; b = ob[t / 10 + 1]; cin = oc[t / 10 + 1]; end
      if (t == 29) start = 1'b0;
    end

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    op8(8'h05, 8'h07, 1'b0, s, c);
    chk("sub_sum0", 64'(s), 64'hFE);
    chk("sub_cout0", 64'(c), 64'd0);
    op8(8'h07, 8'h05, 1'b0, s, c);
    chk("sub_sum1", 64'(s), 64'h02);
    chk("sub_cout1", 64'(c), 64'd1);
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      op8(ra, rb, 1'($urandom), s, c);
      chk("sub_rand_sum", 64'(s), 64'(8'(ra - rb)));
      chk("sub_rand_cout", 64'(c), 64'(ra >= rb));
    end
    sub = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
